// File: rtl/wb_commit_stage_if.sv
// ---------------------------------------------------------------------------
// wb_commit_stage_if
//
// Bundles every signal between the MEM stage, the GRF write port, the hazard
// unit and the MEM/WB commit stage, so the stage's port list stays short.
//
// Signal groups:
//   handshake : in_valid, in_ready, flush
//   decode    : dst_sel, src_sel, ld_type, byte_off, rt_addr, rd_addr
//   operands  : alu_out, mem_rdata, hi_data, lo_data, pc, imm16
//   GRF port  : grf_we, grf_waddr, grf_wdata, grf_ready
//   forwarding: fwd_valid, fwd_addr, fwd_data
//   stats     : retired
//
// Modports:
//   master : the surrounding pipeline (MEM stage, GRF arbiter, hazard unit)
//   slave  : the commit stage itself
// ---------------------------------------------------------------------------
interface wb_commit_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [1:0]        dst_sel;
  logic [2:0]        src_sel;
  logic [2:0]        ld_type;
  logic [1:0]        byte_off;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] hi_data;
  logic [DATA_W-1:0] lo_data;
  logic [31:0]       pc;
  logic [15:0]       imm16;
  logic              grf_we;
  logic [REG_AW-1:0] grf_waddr;
  logic [DATA_W-1:0] grf_wdata;
  logic              grf_ready;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retired;

  // Pipeline side: presents instructions and the GRF grant, observes results.
  modport master (
    output in_valid, flush, dst_sel, src_sel, ld_type, byte_off,
           rt_addr, rd_addr, alu_out, mem_rdata, hi_data, lo_data,
           pc, imm16, grf_ready,
    input  in_ready, grf_we, grf_waddr, grf_wdata,
           fwd_valid, fwd_addr, fwd_data, retired
  );

  // Commit stage side.
  modport slave (
    input  in_valid, flush, dst_sel, src_sel, ld_type, byte_off,
           rt_addr, rd_addr, alu_out, mem_rdata, hi_data, lo_data,
           pc, imm16, grf_ready,
    output in_ready, grf_we, grf_waddr, grf_wdata,
           fwd_valid, fwd_addr, fwd_data, retired
  );

endinterface

// File: rtl/wb_commit_stage.sv
// ---------------------------------------------------------------------------
// wb_commit_stage
//
// Registered MEM/WB commit stage for the pipelined MIPS core. Accepts at most
// one retiring instruction per cycle over a valid/ready handshake, resolves
// the destination register and write-back value (including sub-word load
// extension, link values, lui and HI/LO moves), and keeps the result in a
// one-entry output register that drives the shared GRF write port and the
// forwarding tap. A free-running counter tracks committed instructions.
//
// DATA_W must be 32 or 64.
//
// Ports:
//   clk     : system clock
//   reset_n : asynchronous, active-low reset
//   bus     : wb_commit_stage_if.slave (handshake, operands, GRF port,
//             forwarding tap, retired counter)
// ---------------------------------------------------------------------------
module wb_commit_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_REG    = 31,
  parameter int LINK_OFFSET = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  wb_commit_stage_if.slave bus
);

  localparam logic [1:0] DST_RD   = 2'b00;
  localparam logic [1:0] DST_RT   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;

  localparam logic [2:0] SRC_ALU  = 3'b000;
  localparam logic [2:0] SRC_MEM  = 3'b001;
  localparam logic [2:0] SRC_LINK = 3'b010;
  localparam logic [2:0] SRC_LUI  = 3'b011;
  localparam logic [2:0] SRC_HI   = 3'b100;
  localparam logic [2:0] SRC_LO   = 3'b101;

  localparam logic [2:0] LD_LB    = 3'b001;
  localparam logic [2:0] LD_LBU   = 3'b010;
  localparam logic [2:0] LD_LH    = 3'b011;
  localparam logic [2:0] LD_LHU   = 3'b100;

  // Held entry: valid bit plus the registered GRF write that it represents.
  logic              entryValid;
  logic              weReg;
  logic [REG_AW-1:0] addrReg;
  logic [DATA_W-1:0] dataReg;
  logic [CNT_W-1:0]  retiredCnt;

  logic              inReady;
  logic              accept;
  logic              commit;

  logic [REG_AW-1:0] resolvedAddr;
  logic              writeFlag;
  logic [7:0]        byteVal;
  logic [15:0]       halfVal;
  logic [DATA_W-1:0] loadVal;
  logic [31:0]       linkVal;
  logic [DATA_W-1:0] wbData;

  // The stage can take a new instruction whenever the held entry is gone or
  // is leaving this cycle; flush blocks acceptance outright.
  assign inReady = !bus.flush && (!entryValid || bus.grf_ready);
  assign accept  = bus.in_valid && inReady;
  // A flushed entry is discarded, never committed.
  assign commit  = entryValid && bus.grf_ready && !bus.flush;

  assign bus.in_ready  = inReady;
  assign bus.grf_we    = weReg;
  assign bus.grf_waddr = addrReg;
  assign bus.grf_wdata = dataReg;
  assign bus.fwd_valid = weReg;
  assign bus.fwd_addr  = addrReg;
  assign bus.fwd_data  = dataReg;
  assign bus.retired   = retiredCnt;

  // Destination resolution. Writes aimed at $0 or with no destination still
  // retire, they just never assert the write enable.
  always_comb begin
    resolvedAddr = '0;
    case (bus.dst_sel)
      DST_RD:   resolvedAddr = bus.rd_addr;
      DST_RT:   resolvedAddr = bus.rt_addr;
      DST_LINK: resolvedAddr = REG_AW'(LINK_REG);
      default:  resolvedAddr = '0;
    endcase
    writeFlag = (bus.dst_sel != 2'b11) && (resolvedAddr != '0);
  end

  // Sub-word selection from the low 32 bits of the load data. Halfwords
  // ignore byte_off[0], so a misaligned lh simply reads its aligned half.
  always_comb begin
    byteVal = bus.mem_rdata[7:0];
    case (bus.byte_off)
      2'd0:    byteVal = bus.mem_rdata[7:0];
      2'd1:    byteVal = bus.mem_rdata[15:8];
      2'd2:    byteVal = bus.mem_rdata[23:16];
      default: byteVal = bus.mem_rdata[31:24];
    endcase
    halfVal = bus.byte_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  // Load extension. Width casts of signed operands sign-extend; the word
  // case sign-extends bit 31 so a 64-bit datapath sees MIPS32 lw semantics.
  always_comb begin
    loadVal = DATA_W'($signed(bus.mem_rdata[31:0]));
    case (bus.ld_type)
      LD_LB:   loadVal = DATA_W'($signed(byteVal));
      LD_LBU:  loadVal = DATA_W'(byteVal);
      LD_LH:   loadVal = DATA_W'($signed(halfVal));
      LD_LHU:  loadVal = DATA_W'(halfVal);
      default: loadVal = DATA_W'($signed(bus.mem_rdata[31:0]));
    endcase
  end

  // Write-back source mux. The link value wraps within 32 bits and is then
  // zero-extended; lui is a 32-bit quantity sign-extended to the datapath.
  always_comb begin
    linkVal = bus.pc + 32'(LINK_OFFSET);
    wbData  = '0;
    case (bus.src_sel)
      SRC_ALU:  wbData = bus.alu_out;
      SRC_MEM:  wbData = loadVal;
      SRC_LINK: wbData = DATA_W'(linkVal);
      SRC_LUI:  wbData = DATA_W'($signed({bus.imm16, 16'h0000}));
      SRC_HI:   wbData = bus.hi_data;
      SRC_LO:   wbData = bus.lo_data;
      default:  wbData = '0;
    endcase
  end

  // One-entry output register and retired counter. Flush wins over
  // everything: the entry is dropped, nothing counts, nothing is taken in.
  // Otherwise an accept replaces the entry (committing the old one if it was
  // there), and a lone commit empties it. With grf_ready low and an entry
  // held, neither accept nor commit fires, so everything holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entryValid <= 1'b0;
      weReg      <= 1'b0;
      addrReg    <= '0;
      dataReg    <= '0;
      retiredCnt <= '0;
    end else if (bus.flush) begin
      entryValid <= 1'b0;
      weReg      <= 1'b0;
    end else begin
      if (commit) begin
        retiredCnt <= retiredCnt + CNT_W'(1);
      end
      if (accept) begin
        entryValid <= 1'b1;
        weReg      <= writeFlag;
        addrReg    <= resolvedAddr;
        dataReg    <= wbData;
      end else if (commit) begin
        entryValid <= 1'b0;
        weReg      <= 1'b0;
      end
    end
  end

endmodule
